// File: rtl/slv_rst_ctrl.sv
// slv_rst_ctrl: sequences a timed active-low subordinate reset with isolation and a completion pulse.
module slv_rst_ctrl #(
  parameter int CntWidth    = 10,
  parameter int RstCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rst_req_i,
  input  logic [CntWidth-1:0]    hold_cycles_i,
  input  logic [CntWidth-1:0]    recover_cycles_i,
  output logic                   slv_rst_no,
  output logic                   slv_iso_o,
  output logic                   rst_stat_o,
  output logic                   busy_o,
  output logic [RstCntWidth-1:0] rst_cnt_o
);
  typedef enum logic [2:0] {IDLE, ASSERT, RECOVER, DONE, WAIT_REL} state_e;
  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d, rec_q, rec_d;
  logic [RstCntWidth-1:0] rst_cnt_q, rst_cnt_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rec_d     = rec_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      IDLE: if (rst_req_i) begin
        state_d = ASSERT;
        cnt_d   = (hold_cycles_i == '0) ? CntWidth'(1) : hold_cycles_i;
        rec_d   = (recover_cycles_i == '0) ? CntWidth'(1) : recover_cycles_i;
      end
      ASSERT: if (cnt_q == CntWidth'(1)) begin
        state_d = RECOVER;
        cnt_d   = rec_q;
      end else cnt_d = cnt_q - CntWidth'(1);
      // Count on entry to DONE so the new value is visible alongside rst_stat_o.
      RECOVER: if (cnt_q == CntWidth'(1)) begin
        state_d   = DONE;
        rst_cnt_d = (&rst_cnt_q) ? rst_cnt_q : rst_cnt_q + RstCntWidth'(1);
      end else cnt_d = cnt_q - CntWidth'(1);
      DONE:     state_d = WAIT_REL;
      WAIT_REL: state_d = rst_req_i ? WAIT_REL : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rec_q     <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rec_q     <= rec_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end
  assign slv_rst_no = (state_q != ASSERT);
  assign slv_iso_o  = (state_q != IDLE);
  assign busy_o     = (state_q != IDLE);
  assign rst_stat_o = (state_q == DONE);
  assign rst_cnt_o  = rst_cnt_q;
endmodule

// File: tb/tb_slv_rst_ctrl.sv
// tb_slv_rst_ctrl: directed checks of the subordinate reset sequencer.
module tb_slv_rst_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req;
  logic [9:0] hold_cycles;
  logic [9:0] recover_cycles;
  logic       slv_rst_n;
  logic       slv_iso;
  logic       rst_stat;
  logic       busy;
  logic [7:0] rst_cnt;
  int tests = 0;
  int fails = 0;

  slv_rst_ctrl #(.CntWidth(10), .RstCntWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .rst_req_i(rst_req),
    .hold_cycles_i(hold_cycles), .recover_cycles_i(recover_cycles),
    .slv_rst_no(slv_rst_n), .slv_iso_o(slv_iso), .rst_stat_o(rst_stat),
    .busy_o(busy), .rst_cnt_o(rst_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rst_req = 1'b0;
    hold_cycles = 10'd4;
    recover_cycles = 10'd2;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({slv_rst_n, slv_iso, rst_stat, busy, rst_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_values: got rst_n=%b iso=%b stat=%b busy=%b cnt=%0d, want 1 0 0 0 0",
               slv_rst_n, slv_iso, rst_stat, busy, rst_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    rst_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 8) rst_req = 1'b0;
      tests++;
      if (slv_rst_n !== !(c >= 1 && c <= 4) || rst_stat !== (c == 7) ||
          slv_iso !== (c <= 8) || busy !== (c <= 8)) begin
        fails++;
        $display("FAIL basic cycle %0d: got rst_n=%b stat=%b iso=%b busy=%b, want %b %b %b %b", c,
                 slv_rst_n, rst_stat, slv_iso, busy, !(c <= 4), (c == 7), (c <= 8), (c <= 8));
      end
      if (c == 7) begin
        tests++;
        if (rst_cnt !== 8'd1) begin
          fails++;
          $display("FAIL basic_cnt: got %0d want 1", rst_cnt);
        end
      end
    end
  endtask

  task automatic test_zero();
    do_reset();
    hold_cycles = 10'd0;
    recover_cycles = 10'd0;
    rst_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 4) rst_req = 1'b0;
      tests++;
      if (slv_rst_n !== (c != 1) || rst_stat !== (c == 3) || busy !== (c <= 4)) begin
        fails++;
        $display("FAIL zero cycle %0d: got rst_n=%b stat=%b busy=%b, want %b %b %b", c,
                 slv_rst_n, rst_stat, busy, (c != 1), (c == 3), (c <= 4));
      end
    end
  endtask

  task automatic test_held();
    int lows = 0;
    int stats = 0;
    do_reset();
    rst_req = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      step();
      if (c == 50) rst_req = 1'b0;
      lows += int'(!slv_rst_n);
      stats += int'(rst_stat);
      if (c >= 49) begin
        tests++;
        if (busy !== (c <= 50)) begin
          fails++;
          $display("FAIL held_busy cycle %0d: got %b want %b", c, busy, (c <= 50));
        end
      end
    end
    tests++;
    if (lows != 4 || stats != 1 || rst_cnt !== 8'd1) begin
      fails++;
      $display("FAIL held_once: got lows=%0d stats=%0d cnt=%0d, want 4 1 1", lows, stats, rst_cnt);
    end
  endtask

  task automatic test_mid_change();
    int lows = 0;
    do_reset();
    rst_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 2) begin
        rst_req = 1'b0;
        hold_cycles = 10'd9;
      end
      lows += int'(!slv_rst_n);
      if (c == 7) begin
        tests++;
        if (rst_stat !== 1'b1 || rst_cnt !== 8'd1) begin
          fails++;
          $display("FAIL mid_done: got stat=%b cnt=%0d want 1 1", rst_stat, rst_cnt);
        end
      end
    end
    tests++;
    if (lows != 4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_pulse: got lows=%0d busy=%b want 4 0", lows, busy);
    end
  endtask

  task automatic test_reset_mid();
    int stats = 0;
    do_reset();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({slv_rst_n, slv_iso, busy, rst_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_mid: got rst_n=%b iso=%b busy=%b cnt=%0d want 1 0 0 0",
               slv_rst_n, slv_iso, busy, rst_cnt);
    end
    for (int c = 0; c < 10; c++) begin
      stats += int'(rst_stat);
      step();
    end
    tests++;
    if (stats != 0 || rst_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_nostat: got stats=%0d cnt=%0d want 0 0", stats, rst_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int stats = 0;
    do_reset();
    hold_cycles = 10'd1;
    recover_cycles = 10'd1;
    for (int i = 1; i <= 257; i++) begin
      rst_req = 1'b1;
      step();
      step();
      step();
      stats += int'(rst_stat);
      if (i == 1 || i == 255 || i == 256 || i == 257) begin
        tests++;
        if (rst_cnt !== 8'((i > 255) ? 255 : i)) begin
          fails++;
          $display("FAIL sat_cnt seq %0d: got %0d want %0d", i, rst_cnt, (i > 255) ? 255 : i);
        end
      end
      rst_req = 1'b0;
      step();
      step();
    end
    tests++;
    if (stats != 257 || rst_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_final: got stats=%0d cnt=%0d want 257 255", stats, rst_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_held();
    test_mid_change();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/slv_rst_ctrl.md
# slv_rst_ctrl

Reset sequencer at the subordinate end of the slave guard's reset handshake. It accepts the guard's level reset request and drives a timed active-low reset pulse plus an isolation flag toward the guarded subordinate. After a recovery window it returns a one-cycle completion pulse that clears the guard's request. It sits between the guard's reset-request output and its reset-status input, and drives the subordinate reset tree.

## Interface
Parameters:
- `CntWidth`, default 10: width of the hold and recovery cycle counters.
- `RstCntWidth`, default 8: width of the saturating completed-reset counter.

Ports:
- `clk_i`  in  1: single clock.
- `rst_i`  in  1: reset; synchronous, active-high.
- `rst_req_i`  in  1: level reset request from the guard.
- `hold_cycles_i`  in  CntWidth: number of cycles the subordinate reset is held; 0 is treated as 1.
- `recover_cycles_i`  in  CntWidth: number of cycles waited after reset release; 0 is treated as 1.
- `slv_rst_no`  out  1: active-low reset to the subordinate.
- `slv_iso_o`  out  1: subordinate isolated; traffic must be blanked.
- `rst_stat_o`  out  1: one-cycle completion pulse to the guard's reset-clear input.
- `busy_o`  out  1: a sequence is in progress.
- `rst_cnt_o`  out  RstCntWidth: number of completed sequences, saturating.

## Operation
- FSM states: IDLE, ASSERT, RECOVER, DONE, WAIT_REL. The state register is one-hot or binary (implementer's choice).
- All outputs are registered, or decoded from the state register only. No combinational path from any input to any output.
- IDLE:
  - With rst_req_i=1: go to ASSERT and latch H = max(hold_cycles_i, 1) into the down-counter.
  - Latch R = max(recover_cycles_i, 1) at the same edge.
- ASSERT:
  - slv_rst_no=0, slv_iso_o=1, busy_o=1.
  - Stay for exactly H cycles, then go to RECOVER.
- RECOVER:
  - slv_rst_no=1, slv_iso_o=1, busy_o=1.
  - Stay for exactly R cycles, then go to DONE.
- DONE:
  - One cycle with rst_stat_o=1.
  - rst_cnt_o increments, saturating at all-ones, and the new value is visible in this cycle.
  - Always go to WAIT_REL.
- WAIT_REL:
  - slv_iso_o=1, busy_o=1.
  - Go to IDLE when rst_req_i is sampled low.
  - A request still held high never retriggers a sequence; a new sequence starts only from IDLE.
- Inputs are ignored mid-sequence:
  - rst_req_i dropping during ASSERT or RECOVER does not abort; the sequence completes.
  - Changes to hold_cycles_i or recover_cycles_i after the latching edge have no effect.
- Counters are CntWidth bits. Latched values are never zero, so there is no wrap.

## Timing
- Reset values: state=IDLE, slv_rst_no=1, slv_iso_o=0, rst_stat_o=0, busy_o=0, rst_cnt_o=0.
- rst_i asserted mid-sequence:
  - At the next edge, everything returns to the reset values: slv_rst_no rises and slv_iso_o falls even if H has not elapsed.
  - The aborted sequence is not counted.
- Request sampled high in IDLE at edge t. Cycles are numbered after edge t:
  - slv_rst_no=0 in cycles t+1 .. t+H.
  - RECOVER in cycles t+H+1 .. t+H+R.
  - rst_stat_o=1 in cycle t+H+R+1 only.
  - WAIT_REL from cycle t+H+R+2.
- If rst_req_i is sampled low in WAIT_REL at cycle k, then slv_iso_o=0 and busy_o=0 from cycle k+1.
- Minimum IDLE-to-IDLE time is H+R+2 cycles.
- A request sampled high in the first IDLE cycle after WAIT_REL starts a new sequence with the same timing.
- slv_iso_o and busy_o are identical in all states.

## Test plan
- Basic sequence:
  - Stimulus: hold=4, recover=2, rst_req_i raised at cycle 0, dropped the cycle after rst_stat_o.
  - Required: slv_rst_no low in cycles 1-4; rst_stat_o high in cycle 7 only; rst_cnt_o=1 at cycle 7; slv_iso_o high in cycles 1-8 and low from cycle 9.
- Zero settings:
  - Stimulus: hold=0, recover=0.
  - Required: treated as 1. slv_rst_no low in cycle 1 only; rst_stat_o in cycle 3.
- Request held high:
  - Stimulus: rst_req_i held high for 50 cycles with hold=4, recover=2.
  - Required: exactly one reset pulse and one rst_stat_o pulse; busy_o stays high until one cycle after rst_req_i falls; rst_cnt_o=1.
- Mid-sequence changes:
  - Stimulus: drop rst_req_i and change hold_cycles_i to 9 during ASSERT.
  - Required: the pulse length stays at the latched 4 cycles and the sequence completes normally.
- Reset mid-sequence:
  - Stimulus: assert rst_i in cycle 2 of ASSERT.
  - Required: at the next edge slv_rst_no=1, slv_iso_o=0, busy_o=0, rst_cnt_o=0, and no rst_stat_o pulse.
- Counter saturation:
  - Stimulus: RstCntWidth=8, hold=1, recover=1, run 257 back-to-back sequences.
  - Required: rst_cnt_o reaches 255 and stays at 255. Each sequence still produces its rst_stat_o pulse.
